tft_bounce_box_gen: RTL

//   Pixel source feeding the TFT driver: replaces the static picture generator with an animated test pattern.

---
 rtl/tft_bounce_box_gen.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/tft_bounce_box_gen.sv
//------------------------------------------------------------------------------
// Module   : tft_bounce_box_gen
// Brief    : Animated TFT test pattern: a solid box bouncing off the panel edges,
//            changing palette colour on every bounce. RGB565 out, 1-cycle latency.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tft_bounce_box_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned BOX_W    = 64,
  parameter int unsigned BOX_H    = 64,
  parameter int unsigned STEP     = 2,
  parameter logic [15:0] BG_COLOR = 16'h0000,
  parameter logic [15:0] PAL0     = 16'hF800,
  parameter logic [15:0] PAL1     = 16'h07E0,
  parameter logic [15:0] PAL2     = 16'h001F,
  parameter logic [15:0] PAL3     = 16'hFFFF
) (
  input  logic        clk_33_3m,
  input  logic        rst,
  input  logic        enable,
  input  logic [10:0] x_pos,
  input  logic [10:0] y_pos,
  output logic [15:0] display_data,
  output logic        frame_tick,
  output logic        bounce
);

  localparam logic        c_dir_pos = 1'b0;
  localparam logic        c_dir_neg = 1'b1;
  localparam logic [11:0] c_h_act   = 12'(H_ACTIVE);
  localparam logic [11:0] c_v_act   = 12'(V_ACTIVE);
  localparam logic [11:0] c_box_w   = 12'(BOX_W);
  localparam logic [11:0] c_box_h   = 12'(BOX_H);
  localparam logic [11:0] c_step    = 12'(STEP);
  localparam logic [11:0] c_xmax    = 12'(H_ACTIVE - BOX_W);
  localparam logic [11:0] c_ymax    = 12'(V_ACTIVE - BOX_H);

  logic [10:0] r_box_x, r_box_y;
  logic        r_dir_x, r_dir_y;
  logic [1:0]  r_pal_idx;
  logic [15:0] r_display_data;
  logic        r_frame_tick, r_bounce;

  logic [11:0] w_x, w_y, w_bx, w_by;
  logic        w_in_box, w_blank, w_upd;
  logic [15:0] w_box_color, w_pix;
  logic [10:0] w_nx, w_ny;
  logic        w_ndx, w_ndy, w_hit_x, w_hit_y;

  // All geometry is compared at 12 bits so box_x + BOX_W cannot wrap.
  assign w_x  = {1'b0, x_pos};
  assign w_y  = {1'b0, y_pos};
  assign w_bx = {1'b0, r_box_x};
  assign w_by = {1'b0, r_box_y};

  assign w_in_box = (w_x >= w_bx) && (w_x < w_bx + c_box_w) &&
                    (w_y >= w_by) && (w_y < w_by + c_box_h);
  assign w_blank  = (w_x >= c_h_act) || (w_y >= c_v_act);
  assign w_upd    = (w_y == c_v_act) && (x_pos == 11'd0);

  always_comb begin
    w_box_color = PAL0;
    case (r_pal_idx)
      2'd0:    w_box_color = PAL0;
      2'd1:    w_box_color = PAL1;
      2'd2:    w_box_color = PAL2;
      default: w_box_color = PAL3;
    endcase
  end

  always_comb begin
    w_pix = BG_COLOR;
    if (w_blank)
      w_pix = 16'h0000;
    else if (w_in_box)
      w_pix = w_box_color;
  end

  // X axis: clamp to the edge and reverse whenever the next step would reach it.
  always_comb begin
    w_nx    = r_box_x;
    w_ndx   = r_dir_x;
    w_hit_x = 1'b0;
    if (r_dir_x == c_dir_pos) begin
      if (w_bx + c_step >= c_xmax) begin
        w_nx    = c_xmax[10:0];
        w_ndx   = c_dir_neg;
        w_hit_x = 1'b1;
      end else begin
        w_nx = r_box_x + c_step[10:0];
      end
    end else begin
      if (w_bx <= c_step) begin
        w_nx    = 11'd0;
        w_ndx   = c_dir_pos;
        w_hit_x = 1'b1;
      end else begin
        w_nx = r_box_x - c_step[10:0];
      end
    end
  end

  always_comb begin
    w_ny    = r_box_y;
    w_ndy   = r_dir_y;
    w_hit_y = 1'b0;
    if (r_dir_y == c_dir_pos) begin
      if (w_by + c_step >= c_ymax) begin
        w_ny    = c_ymax[10:0];
        w_ndy   = c_dir_neg;
        w_hit_y = 1'b1;
      end else begin
        w_ny = r_box_y + c_step[10:0];
      end
    end else begin
      if (w_by <= c_step) begin
        w_ny    = 11'd0;
        w_ndy   = c_dir_pos;
        w_hit_y = 1'b1;
      end else begin
        w_ny = r_box_y - c_step[10:0];
      end
    end
  end

  // Position only changes on the first blanking cycle, so a frame never tears.
  always_ff @(posedge clk_33_3m or posedge rst) begin
    if (rst) begin
      r_display_data <= 16'h0000;
      r_frame_tick   <= 1'b0;
      r_bounce       <= 1'b0;
      r_box_x        <= 11'd0;
      r_box_y        <= 11'd0;
      r_dir_x        <= c_dir_pos;
      r_dir_y        <= c_dir_pos;
      r_pal_idx      <= 2'd0;
    end else begin
      r_display_data <= w_pix;
      r_frame_tick   <= w_upd;
      r_bounce       <= 1'b0;
      if (w_upd && enable) begin
        r_box_x <= w_nx;
        r_box_y <= w_ny;
        r_dir_x <= w_ndx;
        r_dir_y <= w_ndy;
        if (w_hit_x || w_hit_y) begin
          r_bounce  <= 1'b1;
          r_pal_idx <= r_pal_idx + 2'd1;
        end
      end
    end
  end

  assign display_data = r_display_data;
  assign frame_tick   = r_frame_tick;
  assign bounce       = r_bounce;

endmodule

`default_nettype wire
